// File: rtl/mand_avm_frame_writer_if.sv
// Pixel-in stream plus Avalon-MM write channel of the frame writer.
// Latency: none, wires only.
// Backpressure: in_ready back to the core, avm_m0_waitrequest back from the slave.
// Ports: in_valid/in_data/in_ready (core -> writer), avm_m0_* (writer -> frame buffer).
// Modports: master = the frame writer, slave = the environment (core and memory).
interface mand_avm_frame_writer_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [WIDTH-1:0]  in_data;
    logic              in_ready;
    logic [ADDR_W-1:0] avm_m0_address;
    logic              avm_m0_write;
    logic [WIDTH-1:0]  avm_m0_writedata;
    logic              avm_m0_waitrequest;

    modport master (
        input  in_valid, in_data, avm_m0_waitrequest,
        output in_ready, avm_m0_address, avm_m0_write, avm_m0_writedata
    );

    modport slave (
        output in_valid, in_data, avm_m0_waitrequest,
        input  in_ready, avm_m0_address, avm_m0_write, avm_m0_writedata
    );
endinterface

// File: rtl/mand_avm_frame_writer.sv
// Buffers a pixel stream in a FIFO and writes one frame into memory, one Avalon-MM write per pixel.
// Latency: a pixel accepted at edge t is on the Avalon bus in the next cycle; 1 pixel/cycle sustained.
// Backpressure: waitrequest freezes address/write/writedata; in_ready drops on a full FIFO or a complete frame.
// Ports: clk, rst (synchronous, active-low), start, bus (pixel stream in, Avalon write master out),
//        busy, done (1-cycle pulse), overflow (sticky), pixel_count (completed writes this frame).
module mand_avm_frame_writer #(
    parameter int              WIDTH       = 32,
    parameter int              ADDR_W      = 32,
    parameter int              DEPTH       = 16,
    parameter int              MAX_H       = 400,
    parameter int              MAX_V       = 300,
    parameter longint unsigned BASE_ADDR   = 0,
    parameter int unsigned     ADDR_STRIDE = 4,
    localparam int             N           = MAX_H * MAX_V,
    localparam int             CNT_W       = $clog2(N + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    mand_avm_frame_writer_if.master bus,
    output logic                   busy,
    output logic                   done,
    output logic                   overflow,
    output logic [CNT_W-1:0]       pixel_count
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W:0]    DEPTH_C  = (PTR_W + 1)'(DEPTH);
    localparam logic [CNT_W-1:0]  N_C      = CNT_W'(N);
    localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(ADDR_STRIDE);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state_q;
    logic [CNT_W-1:0]   in_cnt_q;
    logic [CNT_W-1:0]   wr_cnt_q;
    logic [CNT_W-1:0]   wr_cnt_d;
    logic [ADDR_W-1:0]  addr_q;
    logic               overflow_q;
    logic               busy_q;
    logic               done_q;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     fifo_cnt_q;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic in_rdy;
    logic wr_vld;
    logic push;
    logic pop;

    // Everything below depends on registers only, apart from push/pop which
    // feed next-state logic; no input reaches an output combinationally.
    always_comb begin
        in_rdy   = (state_q == RUN) && (fifo_cnt_q < DEPTH_C) && (in_cnt_q < N_C);
        wr_vld   = ((state_q == RUN) || (state_q == DRAIN)) && (fifo_cnt_q != '0);
        push     = bus.in_valid && in_rdy;
        pop      = wr_vld && !bus.avm_m0_waitrequest;
        wr_cnt_d = wr_cnt_q + CNT_W'(pop);
    end

    assign bus.in_ready         = in_rdy;
    assign bus.avm_m0_write     = wr_vld;
    assign bus.avm_m0_address   = addr_q;
    // Empty FIFO presents zero rather than a stale or never-written entry.
    assign bus.avm_m0_writedata = (fifo_cnt_q != '0) ? mem[rd_ptr_q] : '0;

    assign busy        = busy_q;
    assign done        = done_q;
    assign overflow    = overflow_q;
    assign pixel_count = wr_cnt_q;

    // FIFO storage; needs no reset because the count gates every read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            in_cnt_q   <= '0;
            wr_cnt_q   <= '0;
            addr_q     <= BASE_A;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt_q <= '0;
        end else begin
            done_q <= 1'b0;

            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                in_cnt_q <= in_cnt_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                wr_cnt_q <= wr_cnt_d;
                addr_q   <= addr_q + STRIDE_A;
            end
            if (push && !pop) begin
                fifo_cnt_q <= fifo_cnt_q + (PTR_W + 1)'(1);
            end else if (pop && !push) begin
                fifo_cnt_q <= fifo_cnt_q - (PTR_W + 1)'(1);
            end

            if ((state_q == RUN) && bus.in_valid && !in_rdy) begin
                overflow_q <= 1'b1;
            end

            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= RUN;
                        busy_q     <= 1'b1;
                        in_cnt_q   <= '0;
                        wr_cnt_q   <= '0;
                        addr_q     <= BASE_A;
                        overflow_q <= 1'b0;
                        wr_ptr_q   <= '0;
                        rd_ptr_q   <= '0;
                        fifo_cnt_q <= '0;
                    end
                end
                RUN: begin
                    // When the final write retires in the same cycle the last
                    // pixel count is seen, skip DRAIN so done follows that
                    // write by exactly one cycle.
                    if (in_cnt_q == N_C) begin
                        if (wr_cnt_d == N_C) begin
                            state_q <= DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (wr_cnt_d == N_C) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule
